// File: rtl/fios_job_scheduler_if.sv
// Operand/result RAM and multiplier-side signals of the FIOS job scheduler.
// master = scheduler, slave = RAMs, requesters and multiplier.
interface fios_job_scheduler_if #(
    parameter int s     = 8,
    parameter int PE_NB = 8,
    parameter int N_REQ = 2
);
    localparam int CW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = (s > 1) ? $clog2(s) : 1;

    logic [N_REQ-1:0]    req_i;
    logic [N_REQ-1:0]    grant_o;
    logic [N_REQ-1:0]    done_o;
    logic                err_o;
    logic [CW+WW-1:0]    op_raddr_o;
    logic                a_rd_o;
    logic                b_rd_o;
    logic                p_rd_o;
    logic [16:0]         op_rdata_a_i;
    logic [16:0]         op_rdata_b_i;
    logic [16:0]         op_rdata_p_i;
    logic                mm_start_o;
    logic [PE_NB*17-1:0] mm_a_o;
    logic                mm_a_shift_i;
    logic                mm_b_fetch_i;
    logic                mm_p_fetch_i;
    logic [16:0]         mm_b_o;
    logic [16:0]         mm_p_o;
    logic                mm_RES_push_i;
    logic [16:0]         mm_RES_i;
    logic                mm_done_i;
    logic                res_we_o;
    logic [CW+WW-1:0]    res_waddr_o;
    logic [16:0]         res_wdata_o;

    modport master (
        input  req_i, op_rdata_a_i, op_rdata_b_i, op_rdata_p_i,
        input  mm_a_shift_i, mm_b_fetch_i, mm_p_fetch_i,
        input  mm_RES_push_i, mm_RES_i, mm_done_i,
        output grant_o, done_o, err_o, op_raddr_o, a_rd_o, b_rd_o, p_rd_o,
        output mm_start_o, mm_a_o, mm_b_o, mm_p_o,
        output res_we_o, res_waddr_o, res_wdata_o
    );

    modport slave (
        output req_i, op_rdata_a_i, op_rdata_b_i, op_rdata_p_i,
        output mm_a_shift_i, mm_b_fetch_i, mm_p_fetch_i,
        output mm_RES_push_i, mm_RES_i, mm_done_i,
        input  grant_o, done_o, err_o, op_raddr_o, a_rd_o, b_rd_o, p_rd_o,
        input  mm_start_o, mm_a_o, mm_b_o, mm_p_o,
        input  res_we_o, res_waddr_o, res_wdata_o
    );
endinterface

// File: rtl/fios_job_scheduler.sv
// Round-robin job scheduler sharing one FIOS Montgomery multiplier among
// N_REQ requesters: loads the a window, serves b/p fetches, writes results.
module fios_job_scheduler #(
    parameter int s     = 8,
    parameter int PE_NB = 8,
    parameter int N_REQ = 2
) (
    input logic clock_i,
    input logic reset_n_i,
    fios_job_scheduler_if.master bus
);
    localparam int CW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW   = (s > 1) ? $clog2(s) : 1;
    localparam int LW   = WW + 1;
    localparam int NW   = (s + PE_NB - 1) / PE_NB;
    localparam int WINW = (NW > 1) ? $clog2(NW) : 1;
    localparam int RCW  = $clog2(s + 2);

    typedef enum logic [2:0] {IDLE, LOAD_A, START, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    client;
    logic [CW-1:0]    rr_ptr;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] done_q;
    logic             err_q;
    logic             start_q;
    logic [LW-1:0]    lcnt;
    logic [WINW-1:0]  win;
    logic [WW-1:0]    bcnt;
    logic [WW-1:0]    pcnt;
    logic [RCW-1:0]   rcnt;
    logic [16:0]      a_buf [s];

    logic             arb_hit;
    logic [CW-1:0]    arb_sel;
    logic             a_rd;
    logic             b_rd;
    logic             p_rd;
    logic             res_we;
    logic [WW-1:0]    raddr_word;
    logic [WW-1:0]    cap_idx;
    logic [WW-1:0]    bcnt_nxt;
    logic [WW-1:0]    pcnt_nxt;
    logic [RCW:0]     rcnt_fin;
    logic [PE_NB*17-1:0] mm_a;

    always_comb begin
        arb_hit = 1'b0;
        arb_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!arb_hit && bus.req_i[CW'((32'(rr_ptr) + i) % N_REQ)]) begin
                arb_hit = 1'b1;
                arb_sel = CW'((32'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign a_rd     = (state == LOAD_A) && (lcnt < LW'(s));
    assign b_rd     = (state == RUN) && bus.mm_b_fetch_i;
    assign p_rd     = (state == RUN) && bus.mm_p_fetch_i;
    assign res_we   = (state == RUN) && bus.mm_RES_push_i && (rcnt < RCW'(s));
    assign cap_idx  = WW'(lcnt - 1'b1);
    assign bcnt_nxt = (bcnt == WW'(s - 1)) ? '0 : bcnt + 1'b1;
    assign pcnt_nxt = (pcnt == WW'(s - 1)) ? '0 : pcnt + 1'b1;
    // Final count includes a push landing in the same cycle as mm_done_i.
    assign rcnt_fin = {1'b0, rcnt} + {{RCW{1'b0}}, bus.mm_RES_push_i};

    always_comb begin
        raddr_word = '0;
        if (a_rd)
            raddr_word = WW'(lcnt);
        else if (b_rd)
            raddr_word = bcnt;
        else if (p_rd)
            raddr_word = pcnt;
    end

    always_comb begin
        mm_a = '0;
        for (int unsigned k = 0; k < PE_NB; k++) begin
            if ((k + PE_NB * 32'(win)) < s)
                mm_a[17*k +: 17] = a_buf[WW'(k + PE_NB * 32'(win))];
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            client  <= '0;
            rr_ptr  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            lcnt    <= '0;
            win     <= '0;
            bcnt    <= '0;
            pcnt    <= '0;
            rcnt    <= '0;
            for (int unsigned w = 0; w < s; w++)
                a_buf[w] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_hit) begin
                        client  <= arb_sel;
                        grant_q <= N_REQ'(1) << arb_sel;
                        lcnt    <= '0;
                        state   <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    // RAM data lags the strobe by one cycle, so capture trails the read address.
                    if (lcnt != '0)
                        a_buf[cap_idx] <= bus.op_rdata_a_i;
                    if (lcnt == LW'(s)) begin
                        win     <= '0;
                        start_q <= 1'b1;
                        state   <= START;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    bcnt    <= '0;
                    pcnt    <= '0;
                    rcnt    <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    if (bus.mm_a_shift_i && (win != WINW'(NW - 1)))
                        win <= win + 1'b1;
                    if (bus.mm_b_fetch_i)
                        bcnt <= bcnt_nxt;
                    if (bus.mm_p_fetch_i)
                        pcnt <= pcnt_nxt;
                    if (bus.mm_b_fetch_i && bus.mm_p_fetch_i && (bcnt != pcnt))
                        err_q <= 1'b1;
                    if (bus.mm_RES_push_i && (rcnt <= RCW'(s)))
                        rcnt <= rcnt + 1'b1;
                    if (bus.mm_done_i) begin
                        if (rcnt_fin != (RCW+1)'(s))
                            err_q <= 1'b1;
                        grant_q <= '0;
                        done_q  <= N_REQ'(1) << client;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done_q <= '0;
                    rr_ptr <= (client == CW'(N_REQ - 1)) ? '0 : client + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_o     = grant_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.a_rd_o      = a_rd;
    assign bus.b_rd_o      = b_rd;
    assign bus.p_rd_o      = p_rd;
    assign bus.op_raddr_o  = {client, raddr_word};
    assign bus.mm_start_o  = start_q;
    assign bus.mm_a_o      = mm_a;
    assign bus.mm_b_o      = bus.op_rdata_b_i;
    assign bus.mm_p_o      = bus.op_rdata_p_i;
    assign bus.res_we_o    = res_we;
    assign bus.res_waddr_o = {client, WW'(rcnt)};
    assign bus.res_wdata_o = res_we ? bus.mm_RES_i : '0;
endmodule

// File: tb/tb_fios_job_scheduler.sv
// Scoreboard bench for fios_job_scheduler: stimulus queues expected outputs,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_fios_job_scheduler;
    logic clock;
    logic reset_n;

    fios_job_scheduler_if #(.s(4), .PE_NB(4), .N_REQ(2)) bus ();
    fios_job_scheduler_if #(.s(4), .PE_NB(2), .N_REQ(2)) bus2 ();

    fios_job_scheduler #(.s(4), .PE_NB(4), .N_REQ(2)) dut (
        .clock_i  (clock),
        .reset_n_i(reset_n),
        .bus      (bus)
    );

    fios_job_scheduler #(.s(4), .PE_NB(2), .N_REQ(2)) dut2 (
        .clock_i  (clock),
        .reset_n_i(reset_n),
        .bus      (bus2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [16:0] ram_a [8];
    logic [16:0] ram_b [8];
    logic [16:0] ram_p [8];

    always @(posedge clock) begin
        if (bus.a_rd_o)  bus.op_rdata_a_i  <= ram_a[bus.op_raddr_o];
        if (bus.b_rd_o)  bus.op_rdata_b_i  <= ram_b[bus.op_raddr_o];
        if (bus.p_rd_o)  bus.op_rdata_p_i  <= ram_p[bus.op_raddr_o];
        if (bus2.a_rd_o) bus2.op_rdata_a_i <= ram_a[bus2.op_raddr_o];
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] q_rd    [$];
    logic [127:0] q_bdata [$];
    logic [127:0] q_pdata [$];
    logic [127:0] q_start [$];
    logic [127:0] q_res   [$];
    logic [127:0] q_done  [$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm, input logic [127:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h expected nothing", nm, act);
    endtask

    logic b_pend = 1'b0;
    logic p_pend = 1'b0;

    always @(negedge clock) begin
        if (b_pend) begin
            if (q_bdata.size() == 0) unexp("mm_b_o", bus.mm_b_o);
            else chk("mm_b_o", bus.mm_b_o, q_bdata.pop_front());
        end
        if (p_pend) begin
            if (q_pdata.size() == 0) unexp("mm_p_o", bus.mm_p_o);
            else chk("mm_p_o", bus.mm_p_o, q_pdata.pop_front());
        end
        b_pend = bus.b_rd_o;
        p_pend = bus.p_rd_o;
        if (bus.a_rd_o || bus.b_rd_o || bus.p_rd_o) begin
            if (q_rd.size() == 0) unexp("rd", {bus.a_rd_o, bus.b_rd_o, bus.p_rd_o, bus.op_raddr_o});
            else chk("rd", {bus.a_rd_o, bus.b_rd_o, bus.p_rd_o, bus.op_raddr_o}, q_rd.pop_front());
        end
        if (bus.mm_start_o) begin
            if (q_start.size() == 0) unexp("start", {bus.grant_o, bus.mm_a_o});
            else chk("start", {bus.grant_o, bus.mm_a_o}, q_start.pop_front());
        end
        if (bus.res_we_o) begin
            if (q_res.size() == 0) unexp("res", {bus.res_waddr_o, bus.res_wdata_o});
            else chk("res", {bus.res_waddr_o, bus.res_wdata_o}, q_res.pop_front());
        end
        if (bus.done_o != 2'b00) begin
            if (q_done.size() == 0) unexp("done", bus.done_o);
            else chk("done", bus.done_o, q_done.pop_front());
        end
    end

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!bus.mm_start_o && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (!bus.mm_start_o) unexp("start_timeout", cyc);
    endtask

    task automatic wait_start2();
        int cyc = 0;
        while (!bus2.mm_start_o && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (!bus2.mm_start_o) unexp("start2_timeout", cyc);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (bus.done_o == 2'b00 && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (bus.done_o == 2'b00) unexp("done_timeout", cyc);
    endtask

    // Drive a sequence of result pushes; mm_done_i rides on the last one if requested.
    task automatic push_res(input logic [16:0] d0, input logic [16:0] d1,
                            input logic [16:0] d2, input logic [16:0] d3,
                            input int n, input bit done_with_last);
        logic [16:0] vals [4];
        vals[0] = d0; vals[1] = d1; vals[2] = d2; vals[3] = d3;
        for (int i = 0; i < n; i++) begin
            bus.mm_RES_push_i = 1'b1;
            bus.mm_RES_i      = vals[i];
            bus.mm_done_i     = done_with_last && (i == n - 1);
            @(posedge clock); #1;
        end
        bus.mm_RES_push_i = 1'b0;
        bus.mm_RES_i      = '0;
        if (!done_with_last) begin
            bus.mm_done_i = 1'b1;
            @(posedge clock); #1;
        end
        bus.mm_done_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_grant"}, bus.grant_o, 2'b00);
        chk({tag, "_done"}, bus.done_o, 2'b00);
        chk({tag, "_err"}, bus.err_o, 1'b0);
        chk({tag, "_strobes"}, {bus.a_rd_o, bus.b_rd_o, bus.p_rd_o}, 3'b000);
        chk({tag, "_start"}, bus.mm_start_o, 1'b0);
        chk({tag, "_res_we"}, bus.res_we_o, 1'b0);
        chk({tag, "_mm_a"}, bus.mm_a_o, 68'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 8; i++) begin
            ram_a[i] = 17'(i + 1);
            ram_b[i] = 17'('h10 + i);
            ram_p[i] = 17'('h20 + i);
        end
        reset_n = 1'b0;
        bus.req_i = '0; bus.mm_a_shift_i = 0; bus.mm_b_fetch_i = 0; bus.mm_p_fetch_i = 0;
        bus.mm_RES_push_i = 0; bus.mm_RES_i = '0; bus.mm_done_i = 0;
        bus2.req_i = '0; bus2.mm_a_shift_i = 0; bus2.mm_b_fetch_i = 0; bus2.mm_p_fetch_i = 0;
        bus2.mm_RES_push_i = 0; bus2.mm_RES_i = '0; bus2.mm_done_i = 0;
        bus2.op_rdata_b_i = '0; bus2.op_rdata_p_i = '0;
        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("reset");
        reset_n = 1'b1;

        // Job 1: req=11 held, client 0 first
        for (int w = 0; w < 4; w++) q_rd.push_back({3'b100, 3'(w)});
        q_start.push_back({2'b01, 17'd4, 17'd3, 17'd2, 17'd1});
        @(posedge clock); #1;
        bus.req_i = 2'b11;
        wait_start(cyc);
        chk("load_latency", cyc, 6);
        q_rd.push_back({3'b010, 3'd0}); q_bdata.push_back(17'h10);
        q_rd.push_back({3'b010, 3'd1}); q_bdata.push_back(17'h11);
        q_rd.push_back({3'b010, 3'd2}); q_bdata.push_back(17'h12);
        q_rd.push_back({3'b010, 3'd3}); q_bdata.push_back(17'h13);
        q_rd.push_back({3'b010, 3'd0}); q_bdata.push_back(17'h10);
        @(posedge clock); #1;
        bus.mm_b_fetch_i = 1'b1;
        repeat (5) begin @(posedge clock); #1; end
        bus.mm_b_fetch_i = 1'b0;
        q_res.push_back({3'd0, 17'd9}); q_res.push_back({3'd1, 17'd8});
        q_res.push_back({3'd2, 17'd7}); q_res.push_back({3'd3, 17'd6});
        q_done.push_back(2'b01);
        push_res(17'd9, 17'd8, 17'd7, 17'd6, 4, 1'b1);
        wait_done();
        chk("err_after_full_job", bus.err_o, 1'b0);

        // Job 2: same held request, client 1 next; dual fetch then a short result
        for (int w = 0; w < 4; w++) q_rd.push_back({3'b100, 3'(4 + w)});
        q_start.push_back({2'b10, 17'd8, 17'd7, 17'd6, 17'd5});
        wait_start(cyc);
        q_rd.push_back({3'b011, 3'd4}); q_bdata.push_back(17'h14); q_pdata.push_back(17'h24);
        q_rd.push_back({3'b011, 3'd5}); q_bdata.push_back(17'h15); q_pdata.push_back(17'h25);
        @(posedge clock); #1;
        bus.mm_b_fetch_i = 1'b1;
        bus.mm_p_fetch_i = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        bus.mm_b_fetch_i = 1'b0;
        bus.mm_p_fetch_i = 1'b0;
        q_res.push_back({3'd4, 17'd1}); q_res.push_back({3'd5, 17'd2}); q_res.push_back({3'd6, 17'd3});
        q_done.push_back(2'b10);
        push_res(17'd1, 17'd2, 17'd3, 17'd0, 3, 1'b0);
        wait_done();
        chk("err_after_short_job", bus.err_o, 1'b1);
        bus.req_i = 2'b00;

        // Job 3: round robin is back at client 0; reset abandons it in RUN
        for (int w = 0; w < 4; w++) q_rd.push_back({3'b100, 3'(w)});
        q_start.push_back({2'b01, 17'd4, 17'd3, 17'd2, 17'd1});
        @(posedge clock); #1;
        bus.req_i = 2'b11;
        wait_start(cyc);
        chk("err_sticky", bus.err_o, 1'b1);
        repeat (2) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        bus.req_i = 2'b00;
        #1;
        check_idle_outputs("mid_run_reset");
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Job 4: client 1 granted straight from IDLE after reset
        for (int w = 0; w < 4; w++) q_rd.push_back({3'b100, 3'(4 + w)});
        q_start.push_back({2'b10, 17'd8, 17'd7, 17'd6, 17'd5});
        @(posedge clock); #1;
        bus.req_i = 2'b10;
        wait_start(cyc);
        @(posedge clock); #1;
        q_res.push_back({3'd4, 17'd9}); q_res.push_back({3'd5, 17'd8});
        q_res.push_back({3'd6, 17'd7}); q_res.push_back({3'd7, 17'd6});
        q_done.push_back(2'b10);
        push_res(17'd9, 17'd8, 17'd7, 17'd6, 4, 1'b1);
        wait_done();
        chk("err_after_reset_job", bus.err_o, 1'b0);
        bus.req_i = 2'b00;

        // FOLD window on the PE_NB=2 instance
        @(posedge clock); #1;
        bus2.req_i = 2'b01;
        wait_start2();
        chk("win0", bus2.mm_a_o, {17'd2, 17'd1});
        @(posedge clock); #1;
        bus2.mm_a_shift_i = 1'b1;
        chk("win0_during_shift", bus2.mm_a_o, {17'd2, 17'd1});
        @(posedge clock); #1;
        bus2.mm_a_shift_i = 1'b0;
        chk("win1", bus2.mm_a_o, {17'd4, 17'd3});
        bus2.mm_a_shift_i = 1'b1;
        @(posedge clock); #1;
        bus2.mm_a_shift_i = 1'b0;
        chk("win_saturate", bus2.mm_a_o, {17'd4, 17'd3});

        repeat (3) @(posedge clock);
        #1;
        chk("q_rd_drained", q_rd.size(), 0);
        chk("q_bdata_drained", q_bdata.size(), 0);
        chk("q_pdata_drained", q_pdata.size(), 0);
        chk("q_start_drained", q_start.size(), 0);
        chk("q_res_drained", q_res.size(), 0);
        chk("q_done_drained", q_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fios_job_scheduler.md
Name: fios_job_scheduler

Overview:
- Shares one FIOS Montgomery multiplier instance among N_REQ requesters.
- Uses round-robin arbitration to pick a requester, loads that requester's a operand into a local window buffer, and issues the start pulse.
- While the multiplier runs, it answers the multiplier's b/p fetch requests from the requester's operand memory and writes the RES words back.
- Sits between the operand/result RAMs and the multiplier top level, and owns all job sequencing.

Parameters:
- s, 8, operand length in 17-bit words.
- PE_NB, 8, number of a words presented per window. Must equal the multiplier's PE count: s for EXPAND, fewer for FOLD.
- N_REQ, 2, number of requesters. CW = max(1, $clog2(N_REQ)); WW = max(1, $clog2(s)).

Ports:
- clock_i  in  1  sole clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_i  in  N_REQ  job request per requester; held high until that requester's done pulse.
- grant_o  out  N_REQ  one-hot; the requester currently being served.
- done_o  out  N_REQ  one-cycle pulse when the granted job completes.
- err_o  out  1  sticky; set when the RES word count is not equal to s at mm_done_i.
- op_raddr_o  out  CW+WW  operand RAM address {client, word}. Shared by a, b and p; the operand is chosen by the strobes.
- a_rd_o / b_rd_o / p_rd_o  out  1  read strobes. At most one of them is high in any cycle, except that b_rd_o and p_rd_o may be high together.
- op_rdata_a_i / op_rdata_b_i / op_rdata_p_i  in  17  RAM read data, valid one cycle after the matching strobe.
- mm_start_o  out  1  one-cycle start pulse to the multiplier.
- mm_a_o  out  PE_NB*17  current a window. Word k of the window sits at bits [17k+16:17k].
- mm_a_shift_i  in  1  advance the a window.
- mm_b_fetch_i / mm_p_fetch_i  in  1  multiplier word requests.
- mm_b_o / mm_p_o  out  17  fetched words; forwarded from op_rdata_b_i / op_rdata_p_i.
- mm_RES_push_i  in  1  result word valid.
- mm_RES_i  in  17  result word.
- mm_done_i  in  1  multiplier completion pulse.
- res_we_o  out  1  result RAM write enable.
- res_waddr_o  out  CW+WW  result RAM address {client, word}.
- res_wdata_o  out  17  result RAM write data.

Behaviour:
- Reset (asynchronous, on reset_n_i low): state = IDLE; rr_ptr = 0; grant_o = 0; done_o = 0; err_o = 0; all strobes, mm_start_o and res_we_o = 0; mm_a_o = 0; all counters = 0. A reset during a job abandons it with no done pulse.
- IDLE: if any req_i bit is high, select the first set bit scanning upward (mod N_REQ) from rr_ptr. Latch it as client, set the grant_o one-hot, go to LOAD_A.
- LOAD_A: for word w = 0..s-1 in consecutive cycles, a_rd_o = 1 and op_raddr_o = {client, w}. Each op_rdata_a_i is captured one cycle later into a_buf[w].
  - After the last capture (s+1 cycles in LOAD_A), set win = 0 and go to START.
- START: mm_start_o = 1 for exactly one cycle; clear bcnt, pcnt and rcnt; go to RUN.
- mm_a_o: word k = a_buf[win*PE_NB + k] when that index is < s, else 0.
  - mm_a_shift_i increments win, saturating at ceil(s/PE_NB)-1.
  - The window change is visible the cycle after the shift.
- RUN, fetch service:
  - mm_b_fetch_i drives b_rd_o = 1 combinationally, with op_raddr_o = {client, bcnt}. bcnt increments and wraps s-1 -> 0.
  - mm_p_fetch_i does the same using pcnt.
  - When both fetches are high in the same cycle, b and p share op_raddr_o. This requires bcnt == pcnt; a mismatch sets err_o.
  - mm_b_o and mm_p_o equal the RAM data one cycle after the fetch, giving a fetch-to-data latency of 1.
- RUN, results: each mm_RES_push_i produces, in the same cycle, res_we_o = 1, res_waddr_o = {client, rcnt}, res_wdata_o = mm_RES_i. rcnt then increments; pushes beyond s are not written.
- RUN, completion: on mm_done_i, set err_o if rcnt (including a push in the same cycle) is not equal to s; go to DONE.
  - mm_done_i and the final mm_RES_push_i in the same cycle are legal; that word is written.
- DONE: for one cycle, done_o[client] = 1, grant_o = 0, and rr_ptr = client+1 mod N_REQ. Then return to IDLE. Arbitration restarts the next cycle.
- A req_i deasserted mid-job is ignored; the job runs to completion.
- Events outside RUN (mm_a_shift_i, fetch, push or done) are ignored.
- err_o clears only on reset.

Test Plan:
- s=4, PE_NB=4, N_REQ=2; req_i=01; RAM a={1,2,3,4}. After 5 LOAD_A cycles: mm_a_o = {4,3,2,1}, then one mm_start_o pulse, grant_o=01.
- Same job; model issues 4 b_fetch pulses. Required: op_raddr_o = 0,1,2,3 in order; mm_b_o shows client-0 words 1 cycle after each fetch; a 5th fetch addresses word 0 again.
- req_i=11 held through two jobs: client 0 is served first, then client 1; done_o=01 then 10; rr_ptr returns to 0.
- PE_NB=2, s=4, a={1,2,3,4}: mm_a_o = {2,1}; after mm_a_shift_i, {4,3}; after a second shift, still {4,3}.
- RES pushes 9,8,7,6, with mm_done_i in the same cycle as the 4th push: writes at {c,0..3} with data 9,8,7,6; err_o stays 0. Repeat with only 3 pushes: err_o=1.
- reset_n_i low during RUN: all outputs 0 immediately, no done_o pulse; after release, req_i=10 is granted client 1 from IDLE.
